ctrl_pkt_fifo: RTL and testbench
================================

# ctrl_pkt_fifo

Packet-framed control FIFO pair between the FX3 control-endpoint word stream and the CPU external-FIFO ports (exfifo_if_* / exfifo_of_* / exfifo_rst) of the lms_ctr control system. Inbound, it accumulates host command words and exposes them to the CPU only after a whole fixed-length packet has arrived. Outbound, it collects CPU response words and releases them to the host only after a whole packet has been written. The CPU never sees a partial command, and the host never sees a partial reply.

## Interface
Parameters:
- DATA_W, 32, word width in bits.
- PKT_WORDS, 16, words per packet (64-byte control packet). Power of 2.
- DEPTH_PKTS, 2, packets buffered per direction. Power of 2. Per-direction depth D = PKT_WORDS*DEPTH_PKTS.

Ports:
- clk  in  1  single clock for the whole block.
- reset_n  in  1  asynchronous, active-low reset.
- sw_rst  in  1  synchronous clear, driven by CPU exfifo_rst_export.
- host_in_data  in  DATA_W  inbound word from USB side.
- host_in_valid  in  1  inbound word present.
- host_in_ready  out  1  block can accept an inbound word.
- cpu_if_d  out  DATA_W  head inbound word (show-ahead), to exfifo_if_d_export.
- cpu_if_rd  in  1  pop head inbound word, from exfifo_if_rd_export.
- cpu_if_rdempty  out  1  no committed inbound word, to exfifo_if_rdempty_export.
- cpu_of_d  in  DATA_W  outbound word, from exfifo_of_d_export.
- cpu_of_wr  in  1  write outbound word, from exfifo_of_wr_export.
- cpu_of_wrfull  out  1  outbound buffer full, to exfifo_of_wrfull_export.
- host_out_data  out  DATA_W  head outbound word (show-ahead).
- host_out_valid  out  1  committed outbound word present.
- host_out_ready  in  1  USB side accepts the outbound word.
- ovf_err  out  1  sticky flag: a CPU write was issued while full.

## Operation
- Each direction is a circular RAM of D words with three pointers, each log2(D)+1 bits wide, with a wrap bit: wr_ptr, commit_ptr, rd_ptr. All pointers increment modulo 2·D.
- Fill level = wr_ptr − rd_ptr (modulo 2·D). Full when the fill level equals D. Committed data is present when rd_ptr ≠ commit_ptr.
- Inbound direction:
  - A word is accepted when host_in_valid & host_in_ready. It is written at wr_ptr, and wr_ptr increments.
  - A word-in-packet counter (log2 PKT_WORDS bits) counts accepted words. When the accepted word is number PKT_WORDS−1, commit_ptr ← wr_ptr+1 and the counter wraps to 0.
  - cpu_if_rd while cpu_if_rdempty=1 is ignored, with no pointer change.
- Outbound direction:
  - Mirror of the inbound direction. The CPU is the writer (cpu_of_wr) and the host is the reader (host_out_valid & host_out_ready).
  - cpu_of_wr while cpu_of_wrfull=1 is dropped. It sets ovf_err and does not advance the word counter.
- Partial packets are never visible to the reader. They persist until completed or cleared by reset.
- sw_rst=1: all pointers, counters and ovf_err clear on that clock edge. Partial and committed data in both directions is discarded. Inputs arriving in that cycle are ignored.
- Simultaneous write and read in the same cycle are both legal at any fill level except: a write at full is blocked (inbound ready=0) or dropped (outbound).

## Timing
- Reset values (reset_n=0 or after sw_rst):
  - host_in_ready=1
  - cpu_if_rdempty=1
  - cpu_of_wrfull=0
  - host_out_valid=0
  - ovf_err=0
  - cpu_if_d=0
  - host_out_data=0
- All outputs are registered. Each flag is computed from next-state pointers, so a flag reflects the effect of the current edge's operations from the following cycle.
- Commit latency: the edge that accepts the last word of a packet clears rdempty (inbound) or sets host_out_valid (outbound) in the next cycle. The head data is valid in that same cycle.
- Read: at the edge where the pop occurs, the data output updates to the next word in the next cycle, or to the empty/invalid flag if none remains. Back-to-back pops every cycle are supported.
- Full: the edge accepting the D-th unread word drops host_in_ready / raises cpu_of_wrfull in the next cycle. A pop in that same cycle keeps the buffer not full.
- Data outputs hold their last value while empty or invalid. Testbenches must not check them then.

## Test plan
- Release reset_n → host_in_ready=1, cpu_if_rdempty=1, cpu_of_wrfull=0, host_out_valid=0, ovf_err=0, both data outputs 0x00000000.
- Host sends 15 words 0x1000..0x100E → rdempty stays 1. The 16th word 0x100F → rdempty=0 the next cycle with cpu_if_d=0x1000. 16 consecutive pops return 0x1000..0x100F, and rdempty=1 the cycle after the last pop.
- Host streams 32 words, no CPU reads → host_in_ready=0 the cycle after the 32nd accept, and the 33rd word is held off. One pop → ready=1 next cycle. Words still read back in order.
- CPU writes 16 words 0x2000..0x200F with host_out_ready=0 → host_out_valid=1 the cycle after the 16th write. After 32 writes, wrfull=1. A 33rd write of 0xDEAD is dropped and ovf_err=1. Then drain with ready toggled 1/0 → exactly 0x2000..0x201F, with no 0xDEAD.
- 8 inbound and 5 outbound words written, then a 1-cycle sw_rst pulse → all outputs return to their reset values. A following full 16-word packet in each direction is delivered intact, starting at word 0.
- Five packets pushed through each direction with a write and a read in the same cycles, so the pointers wrap twice → no data loss or reordering. The flags stay consistent at each packet boundary.

Source files
------------

// File: rtl/ctrl_pkt_fifo.sv
// Packet-framed control FIFO pair: host->CPU commands and CPU->host replies.
// Each reader sees only whole PKT_WORDS packets; all outputs are registered.

module ctrl_pkt_fifo_dir #(
    parameter int DATA_W     = 32,
    parameter int PKT_WORDS  = 16,
    parameter int DEPTH_PKTS = 2,
    parameter bit INV_FLAGS  = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              avail_flag_o,
    output logic              full_flag_o
);
    localparam int D  = PKT_WORDS * DEPTH_PKTS;
    localparam int AW = $clog2(D);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(PKT_WORDS);
    localparam logic [PW-1:0] D_P    = PW'(D);
    localparam logic [CW-1:0] LAST_C = CW'(PKT_WORDS - 1);

    logic [DATA_W-1:0] mem_q [D];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              avail_flag_q, avail_flag_d;
    logic              full_flag_q, full_flag_d;
    logic [PW-1:0]     fill_d;
    logic [DATA_W-1:0] head;
    logic              full_now, avail_now, avail_d, wr_en, rd_en;

    // Flags are stored in output polarity (inbound: ready/rdempty, outbound: wrfull/valid)
    assign full_now  = full_flag_q ^ INV_FLAGS;
    assign avail_now = avail_flag_q ^ INV_FLAGS;
    assign wr_en     = wr_i & ~full_now & ~clr_i;
    assign rd_en     = rd_i & avail_now & ~clr_i;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        if (clr_i) begin
            wr_ptr_d     = '0;
            commit_ptr_d = '0;
            rd_ptr_d     = '0;
            cnt_d        = '0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_C) begin
                    commit_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
        fill_d       = wr_ptr_d - rd_ptr_d;
        full_flag_d  = (fill_d == D_P) ^ INV_FLAGS;
        avail_d      = (rd_ptr_d != commit_ptr_d);
        avail_flag_d = avail_d ^ INV_FLAGS;
        // The next head may be the very word written on this edge
        if (wr_en && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head = wdata_i;
        end else begin
            head = mem_q[rd_ptr_d[AW-1:0]];
        end
        rdata_d = rdata_q;
        if (clr_i) begin
            rdata_d = '0;
        end else if (avail_d) begin
            rdata_d = head;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            rdata_q      <= '0;
            avail_flag_q <= INV_FLAGS;
            full_flag_q  <= INV_FLAGS;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            rdata_q      <= rdata_d;
            avail_flag_q <= avail_flag_d;
            full_flag_q  <= full_flag_d;
        end
    end

    assign rdata_o      = rdata_q;
    assign avail_flag_o = avail_flag_q;
    assign full_flag_o  = full_flag_q;
endmodule

module ctrl_pkt_fifo #(
    parameter int DATA_W     = 32,
    parameter int PKT_WORDS  = 16,
    parameter int DEPTH_PKTS = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sw_rst,
    input  logic [DATA_W-1:0] host_in_data,
    input  logic              host_in_valid,
    output logic              host_in_ready,
    output logic [DATA_W-1:0] cpu_if_d,
    input  logic              cpu_if_rd,
    output logic              cpu_if_rdempty,
    input  logic [DATA_W-1:0] cpu_of_d,
    input  logic              cpu_of_wr,
    output logic              cpu_of_wrfull,
    output logic [DATA_W-1:0] host_out_data,
    output logic              host_out_valid,
    input  logic              host_out_ready,
    output logic              ovf_err
);
    logic ovf_err_q, ovf_err_d;

    ctrl_pkt_fifo_dir #(
        .DATA_W(DATA_W), .PKT_WORDS(PKT_WORDS), .DEPTH_PKTS(DEPTH_PKTS), .INV_FLAGS(1'b1)
    ) u_in (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .clr_i       (sw_rst),
        .wr_i        (host_in_valid),
        .wdata_i     (host_in_data),
        .rd_i        (cpu_if_rd),
        .rdata_o     (cpu_if_d),
        .avail_flag_o(cpu_if_rdempty),
        .full_flag_o (host_in_ready)
    );

    ctrl_pkt_fifo_dir #(
        .DATA_W(DATA_W), .PKT_WORDS(PKT_WORDS), .DEPTH_PKTS(DEPTH_PKTS), .INV_FLAGS(1'b0)
    ) u_out (
        .clk_i       (clk),
        .rst_ni      (reset_n),
        .clr_i       (sw_rst),
        .wr_i        (cpu_of_wr),
        .wdata_i     (cpu_of_d),
        .rd_i        (host_out_ready),
        .rdata_o     (host_out_data),
        .avail_flag_o(host_out_valid),
        .full_flag_o (cpu_of_wrfull)
    );

    // Sticky until reset: a CPU write that landed on a full outbound buffer
    always_comb begin
        ovf_err_d = ovf_err_q | (cpu_of_wr & cpu_of_wrfull);
        if (sw_rst) begin
            ovf_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_err_q <= 1'b0;
        end else begin
            ovf_err_q <= ovf_err_d;
        end
    end

    assign ovf_err = ovf_err_q;
endmodule

// File: tb/tb_ctrl_pkt_fifo.sv
// Directed, table-driven bench for ctrl_pkt_fifo (DATA_W=32, 16-word packets, 2 packets deep).
// Inputs change and outputs are sampled on the falling clock edge.

module tb_ctrl_pkt_fifo;
    logic        clk = 1'b0;
    logic        reset_n, sw_rst;
    logic [31:0] host_in_data, cpu_of_d;
    logic        host_in_valid, cpu_if_rd, cpu_of_wr, host_out_ready;
    logic [31:0] cpu_if_d, host_out_data;
    logic        host_in_ready, cpu_if_rdempty, cpu_of_wrfull, host_out_valid, ovf_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        ird;
        logic        ow;
        logic [31:0] od;
        logic        ordy;
        logic        e_ready;
        logic        e_empty;
        logic [31:0] e_ifd;
        logic        c_ifd;
        logic        e_full;
        logic        e_valid;
        logic [31:0] e_outd;
        logic        c_outd;
        logic        e_ovf;
    } vec_t;

    vec_t tbl[$];

    ctrl_pkt_fifo dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sw_rst        (sw_rst),
        .host_in_data  (host_in_data),
        .host_in_valid (host_in_valid),
        .host_in_ready (host_in_ready),
        .cpu_if_d      (cpu_if_d),
        .cpu_if_rd     (cpu_if_rd),
        .cpu_if_rdempty(cpu_if_rdempty),
        .cpu_of_d      (cpu_of_d),
        .cpu_of_wr     (cpu_of_wr),
        .cpu_of_wrfull (cpu_of_wrfull),
        .host_out_data (host_out_data),
        .host_out_valid(host_out_valid),
        .host_out_ready(host_out_ready),
        .ovf_err       (ovf_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sw_rst = 1'b0; host_in_valid = 1'b0; host_in_data = '0; cpu_if_rd = 1'b0;
        cpu_of_wr = 1'b0; cpu_of_d = '0; host_out_ready = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},   32'(host_in_ready),  32'd1);
        chk({tag, "_rdempty"}, 32'(cpu_if_rdempty), 32'd1);
        chk({tag, "_wrfull"},  32'(cpu_of_wrfull),  32'd0);
        chk({tag, "_valid"},   32'(host_out_valid), 32'd0);
        chk({tag, "_ovf"},     32'(ovf_err),        32'd0);
        chk({tag, "_if_d"},    cpu_if_d,            32'h0);
        chk({tag, "_out_d"},   host_out_data,       32'h0);
    endtask

    function automatic vec_t mk();
        vec_t v;
        v.iv = 0; v.id = '0; v.ird = 0; v.ow = 0; v.od = '0; v.ordy = 0;
        v.e_ready = 1; v.e_empty = 1; v.e_ifd = '0; v.c_ifd = 0;
        v.e_full = 0; v.e_valid = 0; v.e_outd = '0; v.c_outd = 0; v.e_ovf = 0;
        return v;
    endfunction

    initial begin
        vec_t v;
        int   ncommit, npop;
        bit   nonempty;

        // Inbound: one packet in, then 16 pops
        for (int i = 0; i < 16; i++) begin
            v = mk(); v.iv = 1; v.id = 32'h1000 + 32'(i);
            if (i == 15) begin v.e_empty = 0; v.e_ifd = 32'h1000; v.c_ifd = 1; end
            tbl.push_back(v);
        end
        for (int j = 0; j < 16; j++) begin
            v = mk(); v.ird = 1;
            if (j < 15) begin v.e_empty = 0; v.e_ifd = 32'h1000 + 32'(j + 1); v.c_ifd = 1; end
            tbl.push_back(v);
        end
        // Outbound: 32 writes with host stalled, overflow write, then toggled drain
        for (int i = 0; i < 32; i++) begin
            v = mk(); v.ow = 1; v.od = 32'h2000 + 32'(i);
            if (i >= 15) begin v.e_valid = 1; v.e_outd = 32'h2000; v.c_outd = 1; end
            if (i == 31) v.e_full = 1;
            tbl.push_back(v);
        end
        v = mk(); v.ow = 1; v.od = 32'hDEAD;
        v.e_valid = 1; v.e_outd = 32'h2000; v.c_outd = 1; v.e_full = 1; v.e_ovf = 1;
        tbl.push_back(v);
        for (int k = 0; k < 32; k++) begin
            for (int ph = 0; ph < 2; ph++) begin
                v = mk(); v.ordy = (ph == 0); v.e_ovf = 1;
                if (k < 31) begin v.e_valid = 1; v.e_outd = 32'h2000 + 32'(k + 1); v.c_outd = 1; end
                tbl.push_back(v);
            end
        end

        // Reset state
        idle_inputs();
        reset_n = 1'b0;
        tick();
        chk_reset_vals("rst_held");
        reset_n = 1'b1;
        tick();
        chk_reset_vals("rst_released");

        foreach (tbl[r]) begin
            host_in_valid = tbl[r].iv; host_in_data = tbl[r].id; cpu_if_rd = tbl[r].ird;
            cpu_of_wr = tbl[r].ow; cpu_of_d = tbl[r].od; host_out_ready = tbl[r].ordy;
            tick();
            chk($sformatf("row%0d_ready", r),   32'(host_in_ready),  32'(tbl[r].e_ready));
            chk($sformatf("row%0d_rdempty", r), 32'(cpu_if_rdempty), 32'(tbl[r].e_empty));
            chk($sformatf("row%0d_wrfull", r),  32'(cpu_of_wrfull),  32'(tbl[r].e_full));
            chk($sformatf("row%0d_valid", r),   32'(host_out_valid), 32'(tbl[r].e_valid));
            chk($sformatf("row%0d_ovf", r),     32'(ovf_err),        32'(tbl[r].e_ovf));
            if (tbl[r].c_ifd)  chk($sformatf("row%0d_if_d", r),  cpu_if_d,      tbl[r].e_ifd);
            if (tbl[r].c_outd) chk($sformatf("row%0d_out_d", r), host_out_data, tbl[r].e_outd);
        end
        idle_inputs();

        // Inbound full: 32 words, 33rd held off, one pop frees a slot
        for (int i = 0; i < 32; i++) begin
            host_in_valid = 1; host_in_data = 32'h3000 + 32'(i);
            tick();
            chk($sformatf("full_w%0d_ready", i),   32'(host_in_ready),  32'(i < 31));
            chk($sformatf("full_w%0d_rdempty", i), 32'(cpu_if_rdempty), 32'(i < 15));
        end
        host_in_data = 32'h3020;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("full_hold%0d_ready", i), 32'(host_in_ready), 32'd0);
            chk($sformatf("full_hold%0d_if_d", i),  cpu_if_d,           32'h3000);
        end
        host_in_valid = 0; cpu_if_rd = 1;
        tick();
        cpu_if_rd = 0;
        chk("full_pop_ready", 32'(host_in_ready), 32'd1);
        for (int k = 1; k < 32; k++) begin
            chk($sformatf("full_rd%0d_d", k), cpu_if_d, 32'h3000 + 32'(k));
            cpu_if_rd = 1;
            tick();
        end
        cpu_if_rd = 0;
        chk("full_drained_rdempty", 32'(cpu_if_rdempty), 32'd1);

        // Partial packets, then sw_rst with inputs active in the same cycle
        for (int i = 0; i < 8; i++) begin
            host_in_valid = 1; host_in_data = 32'h4000 + 32'(i);
            cpu_of_wr = (i < 5); cpu_of_d = 32'h5000 + 32'(i);
            tick();
        end
        idle_inputs();
        chk("partial_rdempty", 32'(cpu_if_rdempty), 32'd1);
        chk("partial_valid",   32'(host_out_valid), 32'd0);
        sw_rst = 1; host_in_valid = 1; host_in_data = 32'hBAD0;
        cpu_of_wr = 1; cpu_of_d = 32'hBAD1; cpu_if_rd = 1; host_out_ready = 1;
        tick();
        idle_inputs();
        chk_reset_vals("swrst");
        for (int i = 0; i < 16; i++) begin
            host_in_valid = 1; host_in_data = 32'h6000 + 32'(i);
            cpu_of_wr = 1; cpu_of_d = 32'h7000 + 32'(i);
            tick();
            chk($sformatf("post_w%0d_rdempty", i), 32'(cpu_if_rdempty), 32'(i < 15));
            chk($sformatf("post_w%0d_valid", i),   32'(host_out_valid), 32'(i == 15));
        end
        idle_inputs();
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("post_rd%0d_if_d", k),  cpu_if_d,      32'h6000 + 32'(k));
            chk($sformatf("post_rd%0d_out_d", k), host_out_data, 32'h7000 + 32'(k));
            cpu_if_rd = 1; host_out_ready = 1;
            tick();
        end
        idle_inputs();
        chk("post_drain_rdempty", 32'(cpu_if_rdempty), 32'd1);
        chk("post_drain_valid",   32'(host_out_valid), 32'd0);

        // Five packets streamed with concurrent reads; pointers wrap past 2*D
        for (int t = 1; t <= 100; t++) begin
            host_in_valid = (t <= 80); host_in_data = 32'h8000 + 32'(t - 1);
            cpu_of_wr     = (t <= 80); cpu_of_d     = 32'h9000 + 32'(t - 1);
            cpu_if_rd      = (t >= 17 && t <= 96);
            host_out_ready = (t >= 17 && t <= 96);
            if (t >= 17 && t <= 96) begin
                chk($sformatf("wrap%0d_if_d", t),  cpu_if_d,      32'h8000 + 32'(t - 17));
                chk($sformatf("wrap%0d_out_d", t), host_out_data, 32'h9000 + 32'(t - 17));
            end
            tick();
            ncommit  = 16 * ((t < 80 ? t : 80) / 16);
            npop     = (t < 96 ? t : 96) - 16;
            if (npop < 0) npop = 0;
            nonempty = (ncommit > npop);
            chk($sformatf("wrap%0d_rdempty", t), 32'(cpu_if_rdempty), 32'(!nonempty));
            chk($sformatf("wrap%0d_valid", t),   32'(host_out_valid), 32'(nonempty));
            chk($sformatf("wrap%0d_ready", t),   32'(host_in_ready),  32'd1);
            chk($sformatf("wrap%0d_wrfull", t),  32'(cpu_of_wrfull),  32'd0);
        end
        idle_inputs();
        chk("wrap_end_ovf", 32'(ovf_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
